div_req_ctrl: RTL and testbench

- Upstream request/response controller for the 32/16 restoring divider core.
- Accepts dividend/divisor requests on a valid/ready handshake, converts signed operands to magnitudes, and launches the core with a one-cycle start pulse.
- Waits for core completion, sign-corrects the quotient and remainder, and holds the result on a valid/ready output until it is consumed.
- Short-circuits divide-by-zero without launching the core, and guards against a hung core with a timeout.

---
 rtl/div_req_ctrl.sv | 168 ++++++++++++++++
 tb/tb_div_req_ctrl.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_req_ctrl.sv
// Request/response controller for the 32/16 restoring divider core.
// Optional two's-complement operation is enabled with the SIGNED_DIV_EN macro.
module div_req_ctrl #(
   parameter int TIMEOUT = 40,
   parameter int CNT_W   = 6
) (
   input  logic        clk,
   input  logic        clear,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_a,
   input  logic [15:0] in_b,
   input  logic        in_signed,
   output logic        div_start,
   output logic [31:0] div_a,
   output logic [15:0] div_b,
   input  logic        div_ready,
   input  logic [31:0] div_q,
   input  logic [15:0] div_r,
   output logic        res_valid,
   input  logic        res_ready,
   output logic [31:0] res_q,
   output logic [15:0] res_r,
   output logic        res_dz,
   output logic        res_ovf,
   output logic        res_to
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LAUNCH,
      S_WAIT,
      S_FIX,
      S_DONE
   } state_t;

   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

   state_t           state, state_next;
   logic [CNT_W-1:0] cnt;
   logic [31:0]      a_mag;
   logic [15:0]      b_mag;
   logic [31:0]      fix_q;
   logic [15:0]      fix_r;
   logic             fix_ovf;
   logic             take;
   logic             expire;

`ifdef SIGNED_DIV_EN
   logic sa_in, sb_in;
   logic sa, sb;

   assign sa_in   = in_a[31] & in_signed;
   assign sb_in   = in_b[15] & in_signed;
   assign a_mag   = sa_in ? (~in_a + 32'd1) : in_a;
   assign b_mag   = sb_in ? (~in_b + 16'd1) : in_b;
   // res_q/res_r hold the raw core result during FIX and are corrected in place.
   assign fix_q   = (sa ^ sb) ? (~res_q + 32'd1) : res_q;
   assign fix_r   = sa ? (~res_r + 16'd1) : res_r;
   assign fix_ovf = sa & sb & res_q[31];

   always_ff @(posedge clk or negedge clear) begin
      if (!clear) begin
         sa <= 1'b0;
         sb <= 1'b0;
      end else if (state == S_IDLE && in_valid) begin
         sa <= sa_in;
         sb <= sb_in;
      end
   end
`else
   logic unused_signed;

   assign unused_signed = in_signed;
   assign a_mag         = in_a;
   assign b_mag         = in_b;
   assign fix_q         = res_q;
   assign fix_r         = res_r;
   assign fix_ovf       = 1'b0;
`endif

   // The first WAIT cycle (cnt==0) may still see the previous operation's done flag.
   assign take   = div_ready && (cnt != '0);
   assign expire = (cnt == TO_LAST);

   always_ff @(posedge clk or negedge clear) begin
      if (!clear) state <= S_IDLE;
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values, independent of statement order.
      else        state <= state_next;
   end

   always_comb begin
      // NOTE: every combinational output gets a default first so no path leaves
      // it unassigned, which would infer a latch.
      state_next = state;
      in_ready   = (state == S_IDLE);
      div_start  = (state == S_LAUNCH);
      res_valid  = (state == S_DONE);
      case (state)
         S_IDLE:   if (in_valid) state_next = (in_b == 16'd0) ? S_DONE : S_LAUNCH;
         S_LAUNCH: state_next = S_WAIT;
         S_WAIT: begin
            if (take)        state_next = S_FIX;
            else if (expire) state_next = S_DONE;
         end
         S_FIX:    state_next = S_DONE;
         S_DONE:   if (res_ready) state_next = S_IDLE;
         default:  state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge clear) begin
      // NOTE: the datapath registers are reset too, so no stale operand or result
      // is visible on the outputs after reset.
      if (!clear) begin
         cnt     <= '0;
         div_a   <= '0;
         div_b   <= '0;
         res_q   <= '0;
         res_r   <= '0;
         res_dz  <= 1'b0;
         res_ovf <= 1'b0;
         res_to  <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (in_valid) begin
                  if (in_b == 16'd0) begin
                     res_dz <= 1'b1;
                     res_q  <= 32'hFFFF_FFFF;
                     res_r  <= in_a[15:0];
                  end else begin
                     div_a <= a_mag;
                     div_b <= b_mag;
                  end
               end
            end
            S_LAUNCH: cnt <= '0;
            S_WAIT: begin
               cnt <= cnt + 1'b1;
               if (take) begin
                  res_q <= div_q;
                  res_r <= div_r;
               end else if (expire) begin
                  res_to <= 1'b1;
                  res_q  <= '0;
                  res_r  <= '0;
               end
            end
            S_FIX: begin
               res_q   <= fix_q;
               res_r   <= fix_r;
               res_ovf <= fix_ovf;
            end
            S_DONE: begin
               if (res_ready) begin
                  res_dz  <= 1'b0;
                  res_ovf <= 1'b0;
                  res_to  <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_div_req_ctrl.sv
// Scoreboard bench for div_req_ctrl: behavioural divider core, random stimulus,
// and a monitor that checks results and latency against a reference model.
module tb_div_req_ctrl;

   localparam int TIMEOUT = 40;
   localparam int M_NORM  = 0;
   localparam int M_STALE = 1;
   localparam int M_HANG  = 2;

   logic        clk = 1'b0;
   logic        clear;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_a;
   logic [15:0] in_b;
   logic        in_signed;
   logic        div_start;
   logic [31:0] div_a;
   logic [15:0] div_b;
   logic        div_ready;
   logic [31:0] div_q;
   logic [15:0] div_r;
   logic        res_valid;
   logic        res_ready;
   logic [31:0] res_q;
   logic [15:0] res_r;
   logic        res_dz;
   logic        res_ovf;
   logic        res_to;

   div_req_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(6)) dut (
      .clk(clk), .clear(clear),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_signed(in_signed),
      .div_start(div_start), .div_a(div_a), .div_b(div_b),
      .div_ready(div_ready), .div_q(div_q), .div_r(div_r),
      .res_valid(res_valid), .res_ready(res_ready),
      .res_q(res_q), .res_r(res_r),
      .res_dz(res_dz), .res_ovf(res_ovf), .res_to(res_to)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] q;
      logic [15:0] r;
      logic        dz;
      logic        ovf;
      logic        to;
      logic [31:0] ma;
      logic [15:0] mb;
      int          lat;
      int          acc;
      int          starts;
      int          launch;
   } exp_t;

   exp_t sb[$];
   int   errors    = 0;
   int   checks    = 0;
   int   cyc       = 0;
   int   start_cnt = 0;
   int   cur_mode  = M_NORM;
   int   cur_lat   = 1;
   logic rr_force  = 1'b0;
   logic rr_val    = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model: result of one request, written from the arithmetic rules.
   function automatic exp_t model(input logic [31:0] a, input logic [15:0] b,
                                  input logic sg, input int mode, input int lat);
      exp_t   e;
      logic   use_sgn;
      longint ai, bi, qi, ri, m;
`ifdef SIGNED_DIV_EN
      use_sgn = sg;
`else
      use_sgn = 1'b0;
`endif
      e = '{q: 32'd0, r: 16'd0, dz: 1'b0, ovf: 1'b0, to: 1'b0, ma: 32'd0, mb: 16'd0,
            lat: 0, acc: 0, starts: 0, launch: 1};
      if (use_sgn) begin
         ai = {{32{a[31]}}, a};
         bi = {{48{b[15]}}, b};
      end else begin
         ai = {32'd0, a};
         bi = {48'd0, b};
      end
      m    = (ai < 0) ? -ai : ai;
      e.ma = m[31:0];
      m    = (bi < 0) ? -bi : bi;
      e.mb = m[15:0];
      if (b == 16'd0) begin
         e.dz     = 1'b1;
         e.q      = 32'hFFFF_FFFF;
         e.r      = a[15:0];
         e.lat    = 1;
         e.launch = 0;
      end else if (mode == M_HANG) begin
         e.to  = 1'b1;
         e.lat = TIMEOUT + 2;
      end else begin
         qi    = ai / bi;
         ri    = ai % bi;
         e.q   = qi[31:0];
         e.r   = ri[15:0];
         e.ovf = use_sgn && (qi > 64'sd2147483647);
         e.lat = ((mode == M_STALE) ? 2 : ((lat < 2) ? 2 : lat)) + 3;
      end
      return e;
   endfunction

   // Behavioural divider core; STALE mode shows a wrong done result in the first WAIT cycle.
   initial begin : core
      logic [31:0] ca;
      logic [15:0] cb;
      int          k, mode, lat;
      logic        busy;
      busy = 1'b0; k = 0; mode = M_NORM; lat = 1; ca = '0; cb = '0;
      div_ready = 1'b0; div_q = '0; div_r = '0;
      forever begin
         @(negedge clk);
         if (div_start) begin
            start_cnt++;
            ca = div_a; cb = div_b; mode = cur_mode; lat = cur_lat; k = 0; busy = 1'b1;
            if (sb.size() > 0) begin
               check("div_a_mag", 64'(div_a), 64'(sb[0].ma));
               check("div_b_mag", 64'(div_b), 64'(sb[0].mb));
            end
            if (mode == M_STALE && cb != 16'd0) begin
               div_ready = 1'b1;
               div_q     = ~(ca / cb);
               div_r     = ~(ca[15:0] ^ cb);
            end else begin
               div_ready = 1'b0;
            end
         end else if (busy) begin
            k++;
            if (mode == M_HANG) div_ready = 1'b0;
            else if (k >= ((mode == M_STALE) ? 2 : lat) && cb != 16'd0) begin
               div_ready = 1'b1;
               div_q     = ca / cb;
               div_r     = 16'(ca % {16'd0, cb});
            end
         end
      end
   end

   initial begin : rr_drv
      res_ready = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         if (rr_force) res_ready = rr_val;
         else          res_ready = ($urandom_range(0, 3) != 0);
      end
   end

   initial begin : monitor
      exp_t e;
      logic prev_valid;
      prev_valid = 1'b0;
      forever begin
         @(negedge clk);
         if (clear && res_valid && !prev_valid) begin
            check("sb_has_entry", 64'(sb.size() > 0), 64'd1);
            if (sb.size() > 0) check("latency", 64'(cyc - sb[0].acc), 64'(sb[0].lat));
         end
         if (clear && res_valid && res_ready && sb.size() > 0) begin
            e = sb.pop_front();
            check("res_q",   64'(res_q),   64'(e.q));
            check("res_r",   64'(res_r),   64'(e.r));
            check("res_dz",  64'(res_dz),  64'(e.dz));
            check("res_ovf", 64'(res_ovf), 64'(e.ovf));
            check("res_to",  64'(res_to),  64'(e.to));
            check("launches", 64'(start_cnt - e.starts), 64'(e.launch));
         end
         prev_valid = res_valid;
      end
   end

   task automatic send(input logic [31:0] a, input logic [15:0] b, input logic sg,
                       input int mode, input int lat);
      exp_t e;
      int   n;
      @(negedge clk);
      in_a = a; in_b = b; in_signed = sg; in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (n >= 500) begin
         check("accept_timeout", 64'(in_ready), 64'd1);
      end else begin
         e        = model(a, b, sg, mode, lat);
         e.acc    = cyc;
         e.starts = start_cnt;
         sb.push_back(e);
         cur_mode = mode;
         cur_lat  = lat;
      end
      @(negedge clk);
      in_valid = 1'b0;
      in_a     = $urandom;
      in_b     = 16'($urandom);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() > 0 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 2000) check("drain_timeout", 64'(sb.size()), 64'd0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_in_ready"},  64'(in_ready),  64'd1);
      check({tag, "_div_start"}, 64'(div_start), 64'd0);
      check({tag, "_div_a"},     64'(div_a),     64'd0);
      check({tag, "_div_b"},     64'(div_b),     64'd0);
      check({tag, "_res_valid"}, 64'(res_valid), 64'd0);
      check({tag, "_res_q"},     64'(res_q),     64'd0);
      check({tag, "_res_r"},     64'(res_r),     64'd0);
      check({tag, "_res_flags"}, 64'({res_dz, res_ovf, res_to}), 64'd0);
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      logic [31:0] a, q0;
      logic [15:0] b, r0;
      int          n, pick;
      clear = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_signed = 1'b0;
      #1;
      check_reset_outputs("reset");
      repeat (3) @(negedge clk);
      clear = 1'b1;

      send(32'd100, 16'd7, 1'b0, M_NORM, 3);
      send(32'hFFFF_FF9C, 16'd7, 1'b1, M_NORM, 4);
      send(32'h1234_5678, 16'd0, 1'b0, M_NORM, 1);
      send(32'h8000_0000, 16'hFFFF, 1'b1, M_NORM, 2);
      send(32'd100, 16'd7, 1'b0, M_HANG, 1);
      send(32'd50000, 16'd123, 1'b0, M_STALE, 1);
      send(32'hFFFF_0000, 16'hFFF9, 1'b1, M_STALE, 1);
      drain();

      // Backpressure: result held for 10 cycles, then released.
      rr_force = 1'b1; rr_val = 1'b0;
      send(32'd100000, 16'd13, 1'b0, M_NORM, 5);
      n = 0;
      while (!res_valid && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("bp_valid_seen", 64'(res_valid), 64'd1);
      q0 = res_q; r0 = res_r;
      repeat (10) begin
         @(negedge clk);
         check("bp_hold_valid", 64'(res_valid), 64'd1);
         check("bp_hold_data", 64'({res_q, res_r}), 64'({q0, r0}));
         check("bp_in_ready", 64'(in_ready), 64'd0);
      end
      rr_val = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("bp_idle_after_release", 64'(in_ready), 64'd1);
      check("bp_valid_dropped", 64'(res_valid), 64'd0);
      rr_force = 1'b0;
      drain();

      // Reset in the middle of WAIT abandons the request.
      send(32'd1000, 16'd3, 1'b0, M_NORM, 2);
      drain();
      send(32'd77777, 16'd9, 1'b0, M_HANG, 1);
      repeat (4) @(negedge clk);
      #2;
      clear = 1'b0;
      #1;
      check_reset_outputs("midreset");
      sb.delete();
      @(negedge clk);
      @(negedge clk);
      clear = 1'b1;
      send(32'd1000, 16'd3, 1'b0, M_NORM, 2);
      drain();

      for (int i = 0; i < 60; i++) begin
         pick = $urandom_range(0, 9);
         case (pick)
            0:       a = 32'h8000_0000;
            1:       a = 32'($urandom_range(0, 300));
            2:       a = -32'($urandom_range(1, 300));
            default: a = $urandom;
         endcase
         pick = $urandom_range(0, 9);
         case (pick)
            0:       b = 16'd0;
            1:       b = 16'hFFFF;
            2:       b = 16'd1;
            3:       b = 16'h8000;
            default: b = 16'($urandom);
         endcase
         pick = $urandom_range(0, 19);
         send(a, b, 1'($urandom_range(0, 1)),
              (pick == 0) ? M_HANG : ((pick < 3) ? M_STALE : M_NORM),
              $urandom_range(1, 8));
      end
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
